// File: rtl/btn_pkg.sv
// Shared types and board-level timing constants for the push-button conditioner.
// Timing constants assume the 65 MHz pixel clock.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  localparam int CLK_HZ       = 65_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int LONG_1S       = CLK_HZ;
  localparam int REPEAT_200MS  = CLK_HZ / 5;

endpackage

// File: rtl/btn_conditioner_sync.sv
// sync_2ff: reset-to-0 double-flop synchroniser for an asynchronous input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic s1;
  (* ASYNC_REG = "TRUE" *) logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner: sync + debounce FSM producing level, press/release,
// long-press and auto-repeat pulses. Ports: clk, rst, btn_in -> btn_level,
// press, btn_release, long_press, btn_repeat (all registered).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = LONG_1S,
  parameter int REPEAT_CYCLES   = REPEAT_200MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press,
  output logic btn_release,
  output logic long_press,
  output logic btn_repeat
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic       btn_s;
  btn_state_t state;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic       long_done;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RELEASED;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      long_done   <= 1'b0;
      btn_level   <= 1'b0;
      press       <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      press       <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;
      btn_repeat  <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (btn_s) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state <= RELEASED;
          end else if (db_cnt == DB_LAST) begin
            state     <= PRESSED;
            press     <= 1'b1;
            btn_level <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          // hold_cnt parks at its last value so long_press cannot re-arm
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (hold_cnt == HOLD_LAST && !long_done) begin
            long_press <= 1'b1;
            long_done  <= 1'b1;
            rep_cnt    <= '0;
          end else if (long_done) begin
            if (rep_cnt == REP_LAST) begin
              btn_repeat <= 1'b1;
              rep_cnt    <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          if (!btn_s) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end
        end
        DB_RELEASE: begin
          // hold/repeat timing is frozen here; a glitch resumes it
          if (btn_s) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state       <= RELEASED;
            btn_release <= 1'b1;
            btn_level   <= 1'b0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            long_done   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a per-edge expected-vector scoreboard.
// Expected pulses are scheduled by absolute edge number from the stimulus.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic press;
  logic btn_release;
  logic long_press;
  logic btn_repeat;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .REPEAT_CYCLES   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .press       (press),
    .btn_release (btn_release),
    .long_press  (long_press),
    .btn_repeat  (btn_repeat)
  );

  int ecnt = 0;
  int nvec = 0;
  int nerr = 0;
  logic exp_lvl = 1'b0;
  int s_press[$];
  int s_rel[$];
  int s_long[$];
  int s_rep[$];
  logic [4:0] sb[$];

  function automatic bit has(input int q[$], input int n);
    foreach (q[i]) if (q[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic b, input string tag);
    logic [4:0] e;
    logic [4:0] got;
    int n;
    rst = r;
    btn_in = b;
    n = ecnt + 1;
    if (r) begin
      s_press.delete();
      s_rel.delete();
      s_long.delete();
      s_rep.delete();
      exp_lvl = 1'b0;
      e = '0;
    end else begin
      if (has(s_press, n)) exp_lvl = 1'b1;
      if (has(s_rel, n)) exp_lvl = 1'b0;
      e = {exp_lvl, has(s_press, n), has(s_rel, n),
           has(s_long, n), has(s_rep, n)};
    end
    sb.push_back(e);
    @(posedge clk);
    ecnt++;
    #1;
    got = {btn_level, press, btn_release, long_press, btn_repeat};
    e = sb.pop_front();
    nvec++;
    assert (got === e) else begin
      nerr++;
      $error("FAIL %s edge=%0d got=%b exp=%b (lvl,prs,rel,lng,rep)",
             tag, ecnt, got, e);
    end
  endtask

  task automatic run(input int n, input logic r, input logic b,
                     input string tag);
    for (int i = 0; i < n; i++) step(r, b, tag);
  endtask

  initial begin
    int b;
    rst = 1'b1;
    btn_in = 1'b1;

    run(5, 1'b1, 1'b1, "t1_rst");
    b = ecnt;
    s_press.push_back(b + 7);
    run(7, 1'b0, 1'b1, "t1_press");
    b = ecnt;
    s_rel.push_back(b + 7);
    run(10, 1'b0, 1'b0, "t1_rel");

    run(3, 1'b0, 1'b1, "t2_bounce");
    run(10, 1'b0, 1'b0, "t2_idle");

    b = ecnt;
    s_press.push_back(b + 7);
    s_long.push_back(b + 27);
    s_rep.push_back(b + 32);
    s_rep.push_back(b + 37);
    s_rep.push_back(b + 42);
    run(40, 1'b0, 1'b1, "t3_hold");
    b = ecnt;
    s_rel.push_back(b + 7);
    run(10, 1'b0, 1'b0, "t3_rel");

    b = ecnt;
    s_press.push_back(b + 7);
    s_long.push_back(b + 29);
    s_rep.push_back(b + 34);
    s_rep.push_back(b + 39);
    run(10, 1'b0, 1'b1, "t4_hold");
    run(2, 1'b0, 1'b0, "t4_glitch");
    run(24, 1'b0, 1'b1, "t4_long");

    run(2, 1'b1, 1'b1, "t5_rst");
    b = ecnt;
    s_press.push_back(b + 7);
    s_long.push_back(b + 27);
    s_rep.push_back(b + 32);
    run(30, 1'b0, 1'b1, "t5_repress");
    b = ecnt;
    s_rel.push_back(b + 7);
    run(10, 1'b0, 1'b0, "t5_rel");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
